// File: rtl/video_source_arbiter.sv
// Selects camera or test-pattern pixel stream for the downstream pipeline, switching only
// at frame boundaries, with a camera-silence watchdog fallback and pattern sequencing.
//
// state      | meaning
// WAIT_START | between frames, waiting for frame_start of the effective source
// IN_FRAME   | forwarding the locked source until its frame_end (or fallback abort)
module video_source_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned HOLD_FRAMES    = 60,
  parameter int unsigned WD_WIDTH       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        src_sel,
  input  logic        fallback_en,
  input  logic        cycle_en,
  input  logic [1:0]  pattern_base,
  input  logic [7:0]  cam_pixel_data,
  input  logic        cam_pixel_valid,
  input  logic        cam_frame_start,
  input  logic        cam_frame_end,
  input  logic [15:0] cam_pixel_x,
  input  logic [15:0] cam_pixel_y,
  input  logic [7:0]  tpg_pixel_data,
  input  logic        tpg_pixel_valid,
  input  logic        tpg_frame_start,
  input  logic        tpg_frame_end,
  input  logic [15:0] tpg_pixel_x,
  input  logic [15:0] tpg_pixel_y,
  output logic [1:0]  tpg_pattern_select,
  output logic [7:0]  pixel_data,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        active_src,
  output logic        fallback_active,
  output logic [15:0] frame_count
);

  localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [WD_WIDTH-1:0] WD_LIMIT  = WD_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic {
    WAIT_START = 1'b0,
    IN_FRAME   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WD_WIDTH-1:0] wd_cnt;
  logic [HOLD_W-1:0]   hold_cnt;

  logic        eff;
  logic        mux_sel;
  logic [7:0]  s_data;
  logic        s_valid, s_fs, s_fe;
  logic [15:0] s_x, s_y;

  logic        active_d, valid_d, fs_d, fe_d;
  logic [7:0]  data_d;
  logic [15:0] x_d, y_d;
  logic        count_inc;
  logic        tpg_end_fwd;

  assign eff     = src_sel | fallback_active;
  assign mux_sel = (state_q == IN_FRAME) ? active_src : eff;

  always_comb begin
    if (mux_sel) begin
      s_data  = tpg_pixel_data;
      s_valid = tpg_pixel_valid;
      s_fs    = tpg_frame_start;
      s_fe    = tpg_frame_end;
      s_x     = tpg_pixel_x;
      s_y     = tpg_pixel_y;
    end else begin
      s_data  = cam_pixel_data;
      s_valid = cam_pixel_valid;
      s_fs    = cam_frame_start;
      s_fe    = cam_frame_end;
      s_x     = cam_pixel_x;
      s_y     = cam_pixel_y;
    end
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_src;
    data_d      = pixel_data;
    x_d         = pixel_x;
    y_d         = pixel_y;
    valid_d     = 1'b0;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    count_inc   = 1'b0;
    tpg_end_fwd = 1'b0;
    case (state_q)
      WAIT_START: begin
        if (s_fs) begin
          active_d = eff;
          data_d   = s_data;
          x_d      = s_x;
          y_d      = s_y;
          valid_d  = s_valid;
          fs_d     = 1'b1;
          state_d  = IN_FRAME;
        end
      end
      IN_FRAME: begin
        // Camera died mid-frame: close it without a pixel so the pipeline never stalls open.
        if (fallback_active && !active_src) begin
          fe_d    = 1'b1;
          state_d = WAIT_START;
        end else begin
          data_d  = s_data;
          x_d     = s_x;
          y_d     = s_y;
          valid_d = s_valid;
          if (s_fe) begin
            fe_d        = 1'b1;
            count_inc   = 1'b1;
            tpg_end_fwd = active_src;
            state_d     = WAIT_START;
          end else begin
            fs_d = s_fs;
          end
        end
      end
      default: state_d = WAIT_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_START;
      active_src  <= 1'b0;
      pixel_data  <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      active_src  <= active_d;
      pixel_data  <= data_d;
      pixel_x     <= x_d;
      pixel_y     <= y_d;
      pixel_valid <= valid_d;
      frame_start <= fs_d;
      frame_end   <= fe_d;
      if (count_inc) frame_count <= frame_count + 16'd1;
    end
  end

  // A camera start in the same cycle the counter saturates suppresses the fallback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt          <= '0;
      fallback_active <= 1'b0;
    end else begin
      if (cam_frame_start)      wd_cnt <= '0;
      else if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + WD_WIDTH'(1);

      if (cam_frame_start || !fallback_en) fallback_active <= 1'b0;
      else if (wd_cnt == WD_LIMIT)         fallback_active <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tpg_pattern_select <= 2'd0;
      hold_cnt           <= '0;
    end else if (!cycle_en) begin
      tpg_pattern_select <= pattern_base;
      hold_cnt           <= '0;
    end else if (tpg_end_fwd) begin
      if (hold_cnt == HOLD_LAST) begin
        tpg_pattern_select <= tpg_pattern_select + 2'd1;
        hold_cnt           <= '0;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: doc/video_source_arbiter.md
Name: video_source_arbiter

Overview:
Sits between the two pixel sources, the OV-camera capture path and test_pattern_generator, and the display/processing pipeline.
- Selects which source drives the downstream pixel stream and switches sources only at frame boundaries.
- Runs a camera-silence watchdog that falls back to the test pattern.
- Sequences the generator's pattern_select, cycling through patterns every N frames in pattern mode.

Parameters:
TIMEOUT_CYCLES, 2000000, clk cycles without cam_frame_start before the camera is declared dead
HOLD_FRAMES, 60, completed pattern frames shown before advancing pattern_select (must be ≥1)
WD_WIDTH, 32, watchdog counter width (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
src_sel  in  1  requested source: 0 camera, 1 test pattern
fallback_en  in  1  enables automatic fallback to pattern on camera timeout
cycle_en  in  1  enables automatic pattern cycling
pattern_base  in  2  pattern used when cycle_en=0
cam_pixel_data / tpg_pixel_data  in  8  source pixel value
cam_pixel_valid / tpg_pixel_valid  in  1  pixel strobe
cam_frame_start / tpg_frame_start  in  1  one-cycle frame start pulse
cam_frame_end / tpg_frame_end  in  1  one-cycle frame end pulse
cam_pixel_x, cam_pixel_y / tpg_pixel_x, tpg_pixel_y  in  16 each  pixel coordinates
tpg_pattern_select  out  2  drives test_pattern_generator pattern_select
pixel_data  out  8  arbitrated pixel
pixel_valid, frame_start, frame_end  out  1 each  arbitrated strobes
pixel_x, pixel_y  out  16 each  arbitrated coordinates
active_src  out  1  source currently locked (0 camera, 1 pattern)
fallback_active  out  1  camera timeout fallback in force
frame_count  out  16  completed frames forwarded, wraps at 65535→0

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0, tpg_pattern_select=0
  - state WAIT_START; watchdog, hold counter and frame_count cleared
- Effective source: eff = src_sel | fallback_active.
- Latency: every forwarded signal is registered. An input at cycle t appears at the outputs at t+1. No combinational input→output paths.
- WAIT_START state:
  - pixel_valid, frame_start and frame_end outputs are 0; data and coordinates hold their last values.
  - On frame_start of source eff at t: active_src<=eff, forward that cycle (frame_start=1 at t+1), go to IN_FRAME.
  - frame_start from the other source is ignored.
- IN_FRAME state:
  - Forward all signals of active_src each cycle. Non-active source signals are ignored.
  - src_sel changes have no effect until the frame ends.
  - On active frame_end: forward it, frame_count+1, go to WAIT_START.
  - Active frame_start while IN_FRAME (truncated frame): forward as a new frame, stay in IN_FRAME, no frame_count increment.
- Watchdog:
  - The counter clears on cam_frame_start; otherwise it increments and saturates at TIMEOUT_CYCLES.
  - fallback_active is set the cycle after the counter equals TIMEOUT_CYCLES while fallback_en=1.
  - fallback_active clears the cycle after cam_frame_start, or immediately next cycle when fallback_en=0.
  - The source change takes effect only at the next WAIT_START.
- Fallback abort: if fallback_active rises while IN_FRAME with active_src=0, the next cycle outputs frame_end=1 and pixel_valid=0 (truncated-frame close). Go to WAIT_START; frame_count is not incremented.
- Pattern sequencing:
  - If cycle_en=0: tpg_pattern_select<=pattern_base every cycle; hold counter cleared.
  - If cycle_en=1: on each forwarded tpg_frame_end with active_src=1, hold counter+1.
    - When the counter reaches HOLD_FRAMES, tpg_pattern_select<=tpg_pattern_select+1 (mod 4, 3→0) and the counter clears.
    - The select changes only on frame_end, so it is stable for the whole of each frame.
- Simultaneous events:
  - Active frame_end and eff-source frame_start in the same cycle: frame_end wins. The start is dropped and the arbiter waits for the next start.
  - cam_frame_start in the same cycle as the watchdog reaches timeout: the clear wins, so no fallback.
- Reset mid-frame: outputs drop to 0 asynchronously; no frame_end is emitted.

Test Plan:
- Bench settings: TIMEOUT_CYCLES=100, HOLD_FRAMES=2.
- src_sel=0, camera frame with start at t=10 and end at t=50 → frame_start=1 at t=11, frame_end=1 at t=51, frame_count=1, active_src=0, tpg stream never appears on outputs.
- src_sel toggled 0→1 at t=30 mid camera frame → camera forwarded to its end; next tpg_frame_start locks active_src=1, first tpg pixel appears one cycle later.
- fallback_en=1, camera silent after start at t=0 (frame open) → fallback_active=1 at t=101, frame_end=1/pixel_valid=0 at t=102, frame_count unchanged. Next tpg frame is forwarded. cam_frame_start → fallback_active=0 next cycle, camera resumes at its following frame.
- cycle_en=1, src_sel=1, 6 complete tpg frames → tpg_pattern_select 0,0→1,1→2,2→3 after frames 2/4/6. Further frames wrap 3→0. cycle_en=0 with pattern_base=2 → select=2 next cycle.
- Same-cycle cam_frame_end and tpg_frame_start with eff=1 → frame_end forwarded, start dropped, no output frame_start until the next tpg_frame_start.
- rst_n low mid-frame → all outputs 0 immediately. After release, the state waits for a fresh frame_start; frame_count=0.
